// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  // Default byte width handed to the transmitter.
  localparam int UART_DATA_W = 8;

  // Arbiter FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_START = 3'd1,
    ARB_XMIT  = 3'd2,
    ARB_GAP   = 3'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] win_o,
  output logic             valid_o
);

  logic [PTR_W:0] idx;

  // Walk the search order backwards so the last match written is the first
  // requester at or after ptr (wrapping modulo N_REQ).
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_REQ)) begin
        idx = idx - (PTR_W+1)'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (idx == (PTR_W+1)'(j) && req_i[j]) begin
          win_o   = idx[PTR_W-1:0];
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter
// Optional busy-rise timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = UART_DATA_W,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic                    arb_busy,
  output logic                    err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  // Reject out-of-range configurations at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_send_q, tx_send_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 done;

  logic [PTR_W-1:0]     pick_win;
  logic                 pick_valid;
  logic [DATA_W-1:0]    pick_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  // Select the winning requester's byte slice.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_win == PTR_W'(k)) begin
        pick_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic; a finished or aborted frame funnels through 'done'.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_send_d = tx_send_q;
    gap_d     = gap_q;
    done      = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_d      = to_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        // A transmitter still busy from an earlier frame stalls arbitration.
        if (!tx_busy && pick_valid) begin
          win_d     = pick_win;
          grant_d   = N_REQ'(1) << pick_win;
          tx_data_d = pick_data;
          tx_send_d = 1'b1;
          state_d   = ARB_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_d      = '0;
`endif
        end
      end
      ARB_START: begin
        if (tx_busy) begin
          state_d = ARB_XMIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (to_q == TO_LAST) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
      end
      ARB_XMIT: begin
        if (!tx_busy) begin
          done = 1'b1;
        end
      end
      ARB_GAP: begin
        if (gap_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (done) begin
      tx_send_d = 1'b0;
      grant_d   = '0;
      ack_d     = grant_q;
      ptr_d     = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      gap_d     = GAP_LOAD;
      state_d   = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      gap_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      gap_q     <= gap_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign arb_busy = (state_q != ARB_IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TMO = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant, ack;
  logic [DW-1:0]   tx_data;
  logic            tx_send, tx_busy, arb_busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .DATA_W     (DW),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .arb_busy (arb_busy),
    .err      (err)
  );

  // Inputs as seen by the DUT at each rising edge.
  logic            s_rst, s_req_busy;
  logic [N-1:0]    s_req;
  logic [N*DW-1:0] s_data;
  always @(posedge clk) begin
    s_rst      <= rst;
    s_req      <= req;
    s_data     <= req_data;
    s_req_busy <= tx_busy;
  end

  // Transmitter: busy for 10 cycles per frame, then waits for send to drop.
  logic xm_en = 1'b1, force_busy = 1'b0, xm_busy = 1'b0, xm_release = 1'b0;
  int   xm_cnt = 0;
  assign tx_busy = xm_busy | force_busy;
  always @(negedge clk) begin
    if (s_rst === 1'b1) begin
      xm_busy    <= 1'b0;
      xm_release <= 1'b0;
    end else if (xm_busy) begin
      if (xm_cnt == 1) begin
        xm_busy    <= 1'b0;
        xm_release <= 1'b1;
      end
      xm_cnt <= xm_cnt - 1;
    end else if (xm_release) begin
      if (!tx_send) xm_release <= 1'b0;
    end else if (xm_en && tx_send) begin
      xm_busy <= 1'b1;
      xm_cnt  <= 10;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Frame-level model: who owns the transmitter, whether busy was seen,
  // how many idle cycles remain, and whose turn is next.
  int            m_owner = -1;
  bit            m_seen  = 0;
  int            m_cool  = 0;
  int            m_ptr   = 0;
  int            m_cyc   = 0;
  int            m_start = 0;
  logic [DW-1:0] m_data  = '0;
  logic [N-1:0]  m_ack   = '0;
  bit            m_err   = 0;
  bit            seen_rst = 0;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic finish_frame(input bit abort);
    m_ack   = onehot(m_owner);
    m_err   = abort;
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cool  = GAP;
  endtask

  task automatic model_step();
    m_ack = '0;
    m_err = 0;
    if (s_rst === 1'b1) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_cool   = 0;
      m_seen   = 0;
      seen_rst = 1;
      return;
    end
    m_cyc++;
    if (m_owner < 0) begin
      if (m_cool > 0) begin
        m_cool--;
      end else if (!s_req_busy && s_req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (s_req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_data  = s_data[m_owner*DW +: DW];
        m_seen  = 0;
        m_start = m_cyc;
      end
    end else if (!m_seen) begin
      if (s_req_busy) m_seen = 1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      else if (m_cyc - m_start == TMO) finish_frame(1);
`endif
    end else if (!s_req_busy) begin
      finish_frame(0);
    end
  endtask

  // Compare process: advance the model, then check every DUT output.
  always @(negedge clk) begin
    model_step();
    if (seen_rst) begin
      check("grant", grant, onehot(m_owner));
      check("ack", ack, m_ack);
      check("tx_send", tx_send, m_owner >= 0);
      check("arb_busy", arb_busy, (m_owner >= 0) || (m_cool > 0));
      check("err", err, m_err);
      if (m_owner >= 0) check("tx_data", tx_data, m_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic wait_ack(input int exp_idx, input string name);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      tick();
      if (ack != '0) got = 1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no ack within 200 cycles, expected ack[%0d]", name, exp_idx);
    end else begin
      check(name, ack, onehot(exp_idx));
    end
  endtask

  task automatic wait_send(input string name);
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (tx_send === 1'b1) got = 1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: tx_send not raised within 100 cycles, expected 1", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    int lat;
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; req_data = '0;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_send", tx_send, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Single request from requester 2.
    set_data(2, 8'hA5);
    req = 4'b0100;
    tick();
    check("single_send", tx_send, 1);
    check("single_grant", grant, 4'b0100);
    check("single_data", tx_data, 8'hA5);
    wait_ack(2, "single_ack");
    req = '0;

    // ptr is now 3: requester 3 must win over 0, then 0.
    set_data(3, 8'h5A);
    set_data(0, 8'hC3);
    req = 4'b1001;
    wait_send("wrap_send1");
    check("wrap_first", grant, 4'b1000);
    check("wrap_data3", tx_data, 8'h5A);
    wait_ack(3, "wrap_ack3");
    req = 4'b0001;
    wait_send("wrap_send2");
    check("wrap_second", grant, 4'b0001);
    check("wrap_data0", tx_data, 8'hC3);
    wait_ack(0, "wrap_ack0");
    req = '0;

    // Requester 1 drops req and scribbles its data while in START.
    set_data(1, 8'h3C);
    req = 4'b0010;
    wait_send("drop_send");
    check("drop_grant", grant, 4'b0010);
    req = '0;
    set_data(1, 8'hFF);
    repeat (3) tick();
    check("drop_data", tx_data, 8'h3C);
    wait_ack(1, "drop_ack");

    // Transmitter busy in IDLE stalls arbitration.
    force_busy = 1'b1;
    set_data(0, 8'h11);
    req = 4'b0001;
    repeat (6) tick();
    check("stall_grant", grant, 0);
    check("stall_send", tx_send, 0);
    force_busy = 1'b0;
    wait_ack(0, "stall_ack");
    req = '0;

    // Reset in the middle of a frame.
    set_data(2, 8'h77);
    req = 4'b0100;
    wait_send("rst_xmit_send");
    repeat (4) tick();
    rst = 1'b1;
    req = '0;
    tick();
    check("rst_xmit_send0", tx_send, 0);
    check("rst_xmit_grant0", grant, 0);
    check("rst_xmit_ack0", ack, 0);
    rst = 1'b0;
    set_data(0, 8'h21);
    set_data(3, 8'h43);
    req = 4'b1001;
    wait_send("post_rst_send");
    check("post_rst_ptr0", grant, 4'b0001);
    wait_ack(0, "post_rst_ack0");
    req = '0;
    set_data(1, 8'h99);
    req = 4'b0010;
    wait_send("post_rst_send1");
    check("post_rst_grant1", grant, 4'b0010);
    check("post_rst_data1", tx_data, 8'h99);
    wait_ack(1, "post_rst_ack1");
    req = '0;

    // All requesters held high: strict rotation, 3-cycle ack-to-send spacing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 8'h40 + 8'(i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(order[g], $sformatf("rr_ack%0d", g));
      set_data(order[g], 8'h50 + 8'(g));
      if (g == 4) begin
        req = '0;
      end else begin
        lat = 0;
        while (tx_send !== 1'b1 && lat < 20) begin
          tick();
          lat++;
        end
        check($sformatf("rr_latency%0d", g), lat, 3);
        check($sformatf("rr_grant%0d", g + 1), grant, onehot(order[g + 1]));
      end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Transmitter never responds: abort after TMO cycles in START.
    xm_en = 1'b0;
    set_data(1, 8'h66);
    req = 4'b0011;
    wait_send("to_send");
    check("to_grant", grant, 4'b0010);
    lat = 0;
    while (tx_send === 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("to_len", lat, TMO);
    check("to_ack", ack, 4'b0010);
    check("to_err", err, 1);
    req = 4'b0001;
    xm_en = 1'b1;
    wait_ack(0, "to_next");
    req = '0;
`endif

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
